// File: rtl/pong_uart_cmd.sv
// pong_uart_cmd: turns single-character ASCII bytes from the UART receiver
// into Pong control signals (start, pause, score clear, remote paddles),
// counts unrecognised bytes, and optionally echoes an acknowledge byte.
// Optional feature macro: PONG_CMD_ACK_EN (acknowledge echo path).
module pong_uart_cmd #(
   parameter int unsigned HOLD_CLKS = 2500000,
   parameter int unsigned ERR_W     = 8
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_RX_DV,
   input  logic [7:0]       i_RX_Byte,
   input  logic             i_TX_Active,
   output logic             o_Game_Start,
   output logic             o_Pause,
   output logic             o_Score_Clear,
   output logic             o_Paddle_Up_P1,
   output logic             o_Paddle_Dn_P1,
   output logic             o_Paddle_Up_P2,
   output logic             o_Paddle_Dn_P2,
   output logic             o_Bad_Cmd,
   output logic [ERR_W-1:0] o_Err_Count,
   output logic             o_TX_DV,
   output logic [7:0]       o_TX_Byte
);

   localparam logic [23:0] HOLD_LD = 24'(HOLD_CLKS);
   // Commands are matched on the byte with bit 5 cleared (case folding).
   localparam logic [7:0] C_S = 8'h53;
   localparam logic [7:0] C_P = 8'h50;
   localparam logic [7:0] C_R = 8'h52;
   localparam logic [7:0] C_W = 8'h57;
   localparam logic [7:0] C_X = 8'h58;
   localparam logic [7:0] C_I = 8'h49;
   localparam logic [7:0] C_M = 8'h4D;

   logic [7:0]       cmd_u_s;
   logic             ack_v_s;
   logic [7:0]       ack_b_s;

   logic             start_q, start_d;
   logic             pause_q, pause_d;
   logic             clr_q, clr_d;
   logic             bad_q, bad_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [23:0]      cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic             dir1_q, dir1_d, dir2_q, dir2_d;
   logic             up1_q, up1_d, dn1_q, dn1_d, up2_q, up2_d, dn2_q, dn2_d;

   // Command decode, paddle hold counters, pause and error counter next state.
   always_comb begin
      cmd_u_s = i_RX_Byte & 8'hDF;
      ack_v_s = 1'b0;
      ack_b_s = 8'h00;
      start_d = 1'b0;
      clr_d   = 1'b0;
      bad_d   = 1'b0;
      pause_d = pause_q;
      err_d   = err_q;
      dir1_d  = dir1_q;
      dir2_d  = dir2_q;
      cnt1_d  = (cnt1_q != 24'd0) ? (cnt1_q - 24'd1) : 24'd0;
      cnt2_d  = (cnt2_q != 24'd0) ? (cnt2_q - 24'd1) : 24'd0;
      if (i_RX_DV) begin
         case (cmd_u_s)
            C_S: begin
               if (!pause_q) begin
                  start_d = 1'b1;
                  ack_v_s = 1'b1;
                  ack_b_s = i_RX_Byte;
               end else begin
                  start_d = 1'b0;
               end
            end
            C_P: begin
               pause_d = ~pause_q;
               ack_v_s = 1'b1;
               ack_b_s = i_RX_Byte;
               if (!pause_q) begin
                  cnt1_d = 24'd0;
                  cnt2_d = 24'd0;
               end else begin
                  pause_d = 1'b0;
               end
            end
            C_R: begin
               clr_d   = 1'b1;
               ack_v_s = 1'b1;
               ack_b_s = i_RX_Byte;
            end
            C_W, C_X: begin
               if (!pause_q) begin
                  cnt1_d  = HOLD_LD;
                  dir1_d  = (cmd_u_s == C_W);
                  ack_v_s = 1'b1;
                  ack_b_s = i_RX_Byte;
               end else begin
                  ack_v_s = 1'b0;
               end
            end
            C_I, C_M: begin
               if (!pause_q) begin
                  cnt2_d  = HOLD_LD;
                  dir2_d  = (cmd_u_s == C_I);
                  ack_v_s = 1'b1;
                  ack_b_s = i_RX_Byte;
               end else begin
                  ack_v_s = 1'b0;
               end
            end
            default: begin
               bad_d   = 1'b1;
               ack_v_s = 1'b1;
               ack_b_s = 8'h3F;
               if (err_q != {ERR_W{1'b1}}) begin
                  err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
               end else begin
                  err_d = err_q;
               end
            end
         endcase
      end else begin
         ack_v_s = 1'b0;
      end
      // A single counter per player guarantees up and down are exclusive.
      up1_d = (cnt1_d != 24'd0) &&  dir1_d;
      dn1_d = (cnt1_d != 24'd0) && !dir1_d;
      up2_d = (cnt2_d != 24'd0) &&  dir2_d;
      dn2_d = (cnt2_d != 24'd0) && !dir2_d;
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         start_q <= 1'b0;
         pause_q <= 1'b0;
         clr_q   <= 1'b0;
         bad_q   <= 1'b0;
         err_q   <= {ERR_W{1'b0}};
         cnt1_q  <= 24'd0;
         cnt2_q  <= 24'd0;
         dir1_q  <= 1'b0;
         dir2_q  <= 1'b0;
         up1_q   <= 1'b0;
         dn1_q   <= 1'b0;
         up2_q   <= 1'b0;
         dn2_q   <= 1'b0;
      end else begin
         start_q <= start_d;
         pause_q <= pause_d;
         clr_q   <= clr_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         cnt1_q  <= cnt1_d;
         cnt2_q  <= cnt2_d;
         dir1_q  <= dir1_d;
         dir2_q  <= dir2_d;
         up1_q   <= up1_d;
         dn1_q   <= dn1_d;
         up2_q   <= up2_d;
         dn2_q   <= dn2_d;
      end
   end

   assign o_Game_Start   = start_q;
   assign o_Pause        = pause_q;
   assign o_Score_Clear  = clr_q;
   assign o_Bad_Cmd      = bad_q;
   assign o_Err_Count    = err_q;
   assign o_Paddle_Up_P1 = up1_q;
   assign o_Paddle_Dn_P1 = dn1_q;
   assign o_Paddle_Up_P2 = up2_q;
   assign o_Paddle_Dn_P2 = dn2_q;

`ifdef PONG_CMD_ACK_EN
   logic       pend_v_q, pend_v_d;
   logic [7:0] pend_b_q, pend_b_d;
   logic       tx_dv_q, tx_dv_d;
   logic [7:0] tx_b_q, tx_b_d;

   // One-deep pending acknowledge: drain when the transmitter is idle, latest wins.
   always_comb begin
      pend_v_d = pend_v_q;
      pend_b_d = pend_b_q;
      tx_dv_d  = 1'b0;
      tx_b_d   = 8'h00;
      if (pend_v_q && !i_TX_Active) begin
         tx_dv_d  = 1'b1;
         tx_b_d   = pend_b_q;
         pend_v_d = 1'b0;
      end else begin
         tx_dv_d  = 1'b0;
      end
      if (ack_v_s) begin
         pend_v_d = 1'b1;
         pend_b_d = ack_b_s;
      end else begin
         pend_b_d = pend_b_d;
      end
   end

   // Acknowledge registers; reset discards any pending byte.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         pend_v_q <= 1'b0;
         pend_b_q <= 8'h00;
         tx_dv_q  <= 1'b0;
         tx_b_q   <= 8'h00;
      end else begin
         pend_v_q <= pend_v_d;
         pend_b_q <= pend_b_d;
         tx_dv_q  <= tx_dv_d;
         tx_b_q   <= tx_b_d;
      end
   end

   assign o_TX_DV   = tx_dv_q;
   assign o_TX_Byte = tx_b_q;
`else
   logic unused_s;
   assign unused_s  = ^{i_TX_Active, ack_v_s, ack_b_s};
   assign o_TX_DV   = 1'b0;
   assign o_TX_Byte = 8'h00;
`endif

endmodule

// File: doc/pong_uart_cmd.md
# pong_uart_cmd

UART command decoder between the UART receiver and the Pong game core. Consumes received bytes plus their data-valid strobe and turns single-character ASCII commands into game-control signals:
- start pulse;
- pause level;
- score-clear pulse;
- per-player paddle up/down levels with a timed hold.

This replaces the direct use of the raw receive strobe as the game-start input and lets a host PC drive the game alongside the debounced push buttons.

## Interface
Parameters:
- HOLD_CLKS, 2500000, cycles a remote paddle level stays high after its last command byte (100 ms at 25 MHz); legal range 1 to 2^24-1.
- ERR_W, 8, width of the bad-command counter.

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Reset  in  1  reset; one clock, reset is synchronous and active-high.
- i_RX_DV  in  1  one-cycle strobe, i_RX_Byte valid.
- i_RX_Byte  in  8  received byte.
- i_TX_Active  in  1  UART transmitter busy.
- o_Game_Start  out  1  one-cycle start pulse.
- o_Pause  out  1  pause level.
- o_Score_Clear  out  1  one-cycle score-reset pulse.
- o_Paddle_Up_P1, o_Paddle_Dn_P1, o_Paddle_Up_P2, o_Paddle_Dn_P2  out  1 each  remote paddle levels.
- o_Bad_Cmd  out  1  one-cycle pulse on an unrecognised byte.
- o_Err_Count  out  ERR_W  saturating count of bad bytes.
- o_TX_DV  out  1  acknowledge-byte strobe.
- o_TX_Byte  out  8  acknowledge byte.

## Operation
Command map; uppercase and lowercase are both accepted:
- 'S'/'s' (0x53/0x73): pulse o_Game_Start.
- 'P'/'p' (0x50/0x70): toggle o_Pause.
- 'R'/'r' (0x52/0x72): pulse o_Score_Clear.
- 'W'/'w': P1 up. 'X'/'x': P1 down. 'I'/'i': P2 up. 'M'/'m': P2 down.
- Any other byte: pulse o_Bad_Cmd; o_Err_Count increments and saturates at all-ones.

Paddle behaviour:
- One 24-bit hold counter per player plus a direction bit.
- A paddle command loads the counter with HOLD_CLKS and sets the direction.
- The output level is (counter != 0) AND the selected direction.
- The counter decrements to 0 each cycle.
- A repeat command reloads the counter (retrigger).
- The opposite direction for the same player switches direction immediately and reloads; up and down are never high together.

Pause:
- While o_Pause=1, 'S' and paddle bytes are ignored. They are not counted as bad and are not acknowledged.
- Both hold counters are forced to 0 in the cycle o_Pause rises.
- 'P' and 'R' are always honoured.

Reset:
- All outputs go to 0, counters clear, o_Pause=0, and any pending acknowledge is discarded.
- Reset takes priority over a coincident i_RX_DV, which is dropped.

## Timing
- Latency: a byte with i_RX_DV high in cycle N produces its response in cycle N+1. This covers the pulse, the toggled o_Pause, rising paddle levels and the o_Err_Count update.
- Pulses last exactly one cycle. Back-to-back strobes (N, N+1) produce back-to-back pulses.
- Paddle level: high from N+1 through N+HOLD_CLKS inclusive, provided no retrigger occurs.
- A retrigger in cycle K extends the level to K+HOLD_CLKS.
- i_RX_DV is sampled only on i_Clk. No handshake back to the receiver; every strobe is consumed.

## Configuration
Macro PONG_CMD_ACK_EN.

Defined:
- Each accepted command queues an echo of the received byte; each bad byte queues '?' (0x3F). Ignored-while-paused bytes queue nothing.
- The queue is a one-deep pending register.
- When it is full and i_TX_Active=0, o_TX_DV pulses for one cycle with o_TX_Byte. The register empties that cycle.
- A new acknowledge arriving while full overwrites the pending byte (latest wins).
- Earliest o_TX_DV is cycle N+2.

Undefined:
- o_TX_DV and o_TX_Byte are tied to 0, no pending logic is built, and i_TX_Active is unused.

## Test plan
- Reset, then send 0x53 → o_Game_Start=1 only in cycle N+1; all other outputs stay 0.
- Run with HOLD_CLKS=10. Send 'W' at N → o_Paddle_Up_P1 high N+1..N+10. Send 'W' again at N+5 → level holds to N+15. Send 'X' at N+7 → up drops and down rises at N+8, so both are never high together.
- Send 'P', then 'I' and 'S' → o_Pause=1; no paddle or start response; o_Err_Count unchanged. Send 'p' → o_Pause=0.
- Send 300 bytes of 0x41 with ERR_W=8 → 300 o_Bad_Cmd pulses; o_Err_Count saturates at 255.
- Assert i_Reset together with i_RX_DV carrying 'R' → no o_Score_Clear. Outputs read 0 the cycle after.
- With PONG_CMD_ACK_EN defined and i_TX_Active=1, send 'S' then 0x41 → after i_TX_Active falls, a single o_TX_DV with o_TX_Byte=0x3F.
